if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the ARM pipeline: owns the program counter, issues fetches to instruction memory over a req/ack handshake, and presents `PC` (fetch address + 4) and `Instruction` to the IF/ID pipeline register. It sits directly upstream of that register. It handles branch redirection, hazard and SRAM freezes, and variable-latency memory. When no instruction is available, it inserts a bubble (`Instruction` = 0, the pipeline NOP).

## Interface
- No parameters; data/address width fixed at 32.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `freeze`  in  1  hazard stall from hazard unit.
- `sram_freeze`  in  1  data-SRAM stall from MEM stage.
- `branch_taken`  in  1  redirect request from EXE.
- `branch_addr`  in  32  redirect target.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; stable while `imem_req` is high and not yet acked.
- `imem_ack`  in  1  single-cycle completion; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  fetched word.
- `instr_valid`  out  1  `Instruction` holds a real fetched word this cycle.
- `PC`  out  32  fetch address + 4 of the presented instruction; otherwise `pc_q` + 4.
- `Instruction`  out  32  fetched word when `instr_valid` is high, else 0.

## Operation
- `stall` = `freeze` | `sram_freeze`. `pc_q` is the fetch address, `tgt_q` is the pending branch target, and `hold_q` is the buffered word.
- States: IDLE, REQ, HOLD, DRAIN.
- **IDLE** (reset state)
  - `imem_req` = 0.
  - If `branch_taken`: `pc_q` <= `branch_addr`.
  - Next state: REQ.
- **REQ**
  - `imem_req` = 1, `imem_addr` = `pc_q`.
  - `branch_taken` & `imem_ack`: discard `rdata`; `pc_q` <= `branch_addr`; stay in REQ.
  - `branch_taken` & !`imem_ack`: `tgt_q` <= `branch_addr`; go to DRAIN.
  - `imem_ack` & !`stall`: present `rdata` (`instr_valid` = 1); `pc_q` <= `pc_q` + 4; stay in REQ (back-to-back fetch).
  - `imem_ack` & `stall`: `hold_q` <= `rdata`; go to HOLD.
- **HOLD**
  - `imem_req` = 0; present `hold_q` (`instr_valid` = 1).
  - `branch_taken`: drop the buffer; `pc_q` <= `branch_addr`; go to REQ.
  - Else if !`stall`: `pc_q` <= `pc_q` + 4; go to REQ.
- **DRAIN**
  - `imem_req` = 1 with the old `imem_addr` (a request is never withdrawn).
  - `instr_valid` = 0 throughout.
  - `branch_taken`: `tgt_q` <= `branch_addr` (latest branch wins).
  - On `imem_ack`: discard `rdata`; `pc_q` <= `branch_taken` ? `branch_addr` : `tgt_q`; go to REQ.
- **Priority:** `branch_taken` > `imem_ack`/`stall`. A branch is honoured even while stalled; squashing the instruction in IF/ID is the flush logic's job.
- **Arithmetic:** `pc_q` + 4 is modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
- **Instruction 0x00000000 from memory:** presented with `instr_valid` = 1. It is treated as a NOP downstream.

## Timing
- **Reset values:** state = IDLE, `pc_q` = 0, `tgt_q` = 0, `hold_q` = 0, `imem_req` = 0, `imem_addr` = 0, `instr_valid` = 0, `Instruction` = 0, `PC` = 4.
- **Reset mid-operation:** aborts any outstanding request with no drain. Memory must also reset on `rst`.
- **First request:** first cycle after `rst` deasserts is IDLE; `imem_req` rises in the second cycle.
- **Latency:** fetch-to-present is 0 cycles after `imem_ack`. All outputs are combinational from state, registers and `imem_rdata`/`imem_ack`. The IF/ID register captures at the ack edge.
- **Throughput:** zero-wait memory (ack in the first REQ cycle) sustains 1 instruction/cycle. N wait cycles give 1 instruction per N+1 cycles.
- **Branch cost:**
  - Branch with no outstanding request, or with a same-cycle ack: new request in the next cycle.
  - Branch during a wait: remaining wait on the stale request plus 1 cycle.
- **During `stall` in REQ without ack:** the request continues; nothing is dropped.

## Structure
- Shared `arm_pkg` holds:
  - `NOP_INSTR` = 32'h0
  - `PC_INC` = 4
  - `fetch_state_t` enum {IDLE, REQ, HOLD, DRAIN}
  - `ADDR_W` = 32
- One sub-module, `pc_register`: 32-bit register with sync reset, load-enable and load-value. It is reused for `pc_q`.
- FSM and output muxing stay inline in `if_fetch_stage`.

## Test plan
- **Reset, zero-wait memory:** `mem[0..8]` = 0x11,0x22,0x33 -> `imem_addr` 0,4,8 on consecutive cycles; `Instruction` 0x11,0x22,0x33 with `PC` 4,8,12.
- **3-wait memory:** `instr_valid` = 0 and `Instruction` = 0 for 3 cycles, then word at addr 0 with `PC` = 4; next `imem_addr` = 4.
- **Freeze at ack:** `freeze` = 1 for 2 cycles at ack of addr 8 -> HOLD presents the same word for 2 cycles with `imem_req` = 0. After release, `imem_addr` = 12.
- **Branch during wait:** `branch_taken` to 0x100 while waiting on addr 4 -> stale ack discarded (`instr_valid` = 0). Next `imem_addr` = 0x100; delivered `PC` = 0x104.
- **Branch during HOLD:** `branch_addr` 0x40 -> buffer dropped; `imem_addr` = 0x40 next cycle.
- **Wrap and mid-operation reset:** `pc_q` = 0xFFFFFFFC -> next `imem_addr` = 0. Asserting `rst` while in REQ returns to IDLE with all outputs at reset values the next cycle.

Source files
------------

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared constants and types for the ARM pipeline fetch logic
package arm_pkg;

    localparam int          ADDR_W    = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// rtl/pc_register.sv - 32-bit register with synchronous reset and load enable
module pc_register
    import arm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] d,
    output logic [ADDR_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage: PC ownership, imem req/ack, branch redirect, stall buffering
module if_fetch_stage
    import arm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              sram_freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] PC,
    output logic [31:0]       Instruction
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] tgt_q;
    logic [31:0]       hold_q;
    logic              pc_load;
    logic              tgt_load;
    logic              hold_load;
    logic              stall;

    assign stall     = freeze | sram_freeze;
    assign pc_inc    = pc_q + PC_INC;
    assign imem_addr = pc_q;
    assign PC        = pc_inc;

    pc_register u_pc (
        .clk  (clk),
        .rst  (rst),
        .load (pc_load),
        .d    (pc_d),
        .q    (pc_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (tgt_load) begin
                tgt_q <= branch_addr;
            end
            if (hold_load) begin
                hold_q <= imem_rdata;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_load     = 1'b0;
        pc_d        = pc_inc;
        tgt_load    = 1'b0;
        hold_load   = 1'b0;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        Instruction = NOP_INSTR;

        case (state_q)
            IDLE: begin
                if (branch_taken) begin
                    pc_load = 1'b1;
                    pc_d    = branch_addr;
                end
                state_d = REQ;
            end

            REQ: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    if (imem_ack) begin
                        pc_load = 1'b1;
                        pc_d    = branch_addr;
                    end else begin
                        tgt_load = 1'b1;
                        state_d  = DRAIN;
                    end
                end else if (imem_ack) begin
                    if (!stall) begin
                        instr_valid = 1'b1;
                        Instruction = imem_rdata;
                        pc_load     = 1'b1;
                    end else begin
                        hold_load = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end

            HOLD: begin
                instr_valid = 1'b1;
                Instruction = hold_q;
                if (branch_taken) begin
                    pc_load = 1'b1;
                    pc_d    = branch_addr;
                    state_d = REQ;
                end else if (!stall) begin
                    pc_load = 1'b1;
                    state_d = REQ;
                end
            end

            DRAIN: begin
                // The stale request must complete before the redirect can be issued.
                imem_req = 1'b1;
                tgt_load = branch_taken;
                if (imem_ack) begin
                    pc_load = 1'b1;
                    pc_d    = branch_taken ? branch_addr : tgt_q;
                    state_d = REQ;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        sram_freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] PC;
    logic [31:0] Instruction;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .sram_freeze  (sram_freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .PC           (PC),
        .Instruction  (Instruction)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Instruction memory contents; address 0xC holds a zero word on purpose.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11;
            32'h4:   return 32'h22;
            32'h8:   return 32'h33;
            32'hC:   return 32'h0;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
        endcase
    endfunction

    int   mem_lat_cfg = 0;
    int   mem_lat = 0;
    int   mem_cnt = 0;
    logic req_s = 1'b0;

    function automatic int pick_lat();
        return (mem_lat_cfg >= 0) ? mem_lat_cfg : int'($urandom_range(0, 3));
    endfunction

    // Reference model: started / holding / draining flags plus addresses.
    bit          m_started, m_hold, m_drain;
    logic [31:0] m_pc, m_tgt, m_hword;

    task automatic model_reset();
        m_started = 0; m_hold = 0; m_drain = 0;
        m_pc = '0; m_tgt = '0; m_hword = '0;
    endtask

    task automatic drive(input logic r, input logic b, input logic [31:0] ba,
                         input logic f, input logic sf);
        logic        exp_valid;
        logic [31:0] exp_instr;
        rst = r; branch_taken = b; branch_addr = ba; freeze = f; sram_freeze = sf;
        req_s      = imem_req;
        imem_ack   = !r && imem_req && (mem_cnt == mem_lat);
        imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        #1;
        exp_valid = m_hold || (m_started && !m_drain && imem_ack && !b && !(f | sf));
        exp_instr = !exp_valid ? 32'h0 : (m_hold ? m_hword : mem_word(m_pc));
        check("m_req",   imem_req,    m_started && !m_hold);
        check("m_addr",  imem_addr,   m_pc);
        check("m_valid", instr_valid, exp_valid);
        check("m_instr", Instruction, exp_instr);
        check("m_pc",    PC,          m_pc + 32'd4);
    endtask

    task automatic advance();
        logic        stl;
        logic [31:0] old_tgt;
        @(posedge clk);
        stl     = freeze | sram_freeze;
        old_tgt = m_tgt;
        if (rst) begin
            model_reset();
            mem_cnt = 0;
            mem_lat = pick_lat();
        end else begin
            if (!m_started) begin
                m_started = 1;
                if (branch_taken) m_pc = branch_addr;
            end else if (m_hold) begin
                if (branch_taken) begin
                    m_pc = branch_addr; m_hold = 0;
                end else if (!stl) begin
                    m_pc = m_pc + 32'd4; m_hold = 0;
                end
            end else if (m_drain) begin
                if (branch_taken) m_tgt = branch_addr;
                if (imem_ack) begin
                    m_pc    = branch_taken ? branch_addr : old_tgt;
                    m_drain = 0;
                end
            end else if (branch_taken) begin
                if (imem_ack) m_pc = branch_addr;
                else begin
                    m_tgt = branch_addr; m_drain = 1;
                end
            end else if (imem_ack) begin
                if (!stl) m_pc = m_pc + 32'd4;
                else begin
                    m_hword = mem_word(m_pc); m_hold = 1;
                end
            end
            if (imem_ack) begin
                mem_cnt = 0;
                mem_lat = pick_lat();
            end else if (req_s) begin
                mem_cnt++;
            end
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   imem_req,    1'b0);
        check({tag, "_addr"},  imem_addr,   32'h0);
        check({tag, "_valid"}, instr_valid, 1'b0);
        check({tag, "_instr"}, Instruction, 32'h0);
        check({tag, "_pc"},    PC,          32'h4);
    endtask

    task automatic do_reset(input int lat);
        mem_lat_cfg = lat;
        rst = 1; branch_taken = 0; freeze = 0; sram_freeze = 0; imem_ack = 0;
        repeat (2) @(posedge clk);
        model_reset();
        mem_cnt = 0;
        mem_lat = pick_lat();
        #1;
        check_reset_outputs("rst");
    endtask

    task automatic plain_cycle();
        drive(0, 0, 32'h0, 0, 0);
        advance();
    endtask

    logic [31:0] t1_words[3] = '{32'h11, 32'h22, 32'h33};

    initial begin
        // Zero-wait memory: back-to-back fetches
        do_reset(0);
        drive(0, 0, 32'h0, 0, 0);
        check("t1_idle_req", imem_req, 1'b0);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 32'h0, 0, 0);
            check("t1_addr",  imem_addr,   32'(i * 4));
            check("t1_instr", Instruction, t1_words[i]);
            check("t1_pc",    PC,          32'(i * 4 + 4));
            advance();
        end

        // Three wait cycles before the first word
        do_reset(3);
        plain_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 32'h0, 0, 0);
            check("t2_wait_valid", instr_valid, 1'b0);
            check("t2_wait_instr", Instruction, 32'h0);
            advance();
        end
        drive(0, 0, 32'h0, 0, 0);
        check("t2_instr", Instruction, 32'h11);
        check("t2_pc",    PC,          32'h4);
        advance();
        drive(0, 0, 32'h0, 0, 0);
        check("t2_next_addr", imem_addr, 32'h4);
        advance();

        // Freeze at the ack of address 8
        do_reset(0);
        plain_cycle();
        plain_cycle();
        plain_cycle();
        drive(0, 0, 32'h0, 1, 0);
        check("t3_addr8", imem_addr, 32'h8);
        advance();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 32'h0, (i == 0), 0);
            check("t3_hold_req",   imem_req,    1'b0);
            check("t3_hold_valid", instr_valid, 1'b1);
            check("t3_hold_instr", Instruction, 32'h33);
            advance();
        end
        drive(0, 0, 32'h0, 0, 0);
        check("t3_addr12",   imem_addr,   32'hC);
        check("t3_zero_vld", instr_valid, 1'b1);
        check("t3_zero_ins", Instruction, 32'h0);
        advance();

        // Branch while waiting on address 4
        do_reset(2);
        plain_cycle();
        for (int i = 0; i < 3; i++) plain_cycle();
        drive(0, 1, 32'h100, 0, 0);
        check("t4_addr4", imem_addr, 32'h4);
        advance();
        drive(0, 0, 32'h0, 0, 0);
        check("t4_drain_req",   imem_req,    1'b1);
        check("t4_drain_addr",  imem_addr,   32'h4);
        check("t4_drain_valid", instr_valid, 1'b0);
        advance();
        drive(0, 0, 32'h0, 0, 0);
        check("t4_stale_valid", instr_valid, 1'b0);
        check("t4_stale_instr", Instruction, 32'h0);
        advance();
        drive(0, 0, 32'h0, 0, 0);
        check("t4_target", imem_addr, 32'h100);
        advance();
        plain_cycle();
        drive(0, 0, 32'h0, 0, 0);
        check("t4_pc",    PC,          32'h104);
        check("t4_instr", Instruction, mem_word(32'h100));
        advance();

        // Branch during HOLD
        do_reset(0);
        plain_cycle();
        drive(0, 0, 32'h0, 0, 1);
        advance();
        drive(0, 1, 32'h40, 0, 0);
        check("t5_hold_instr", Instruction, 32'h11);
        advance();
        drive(0, 0, 32'h0, 0, 0);
        check("t5_addr", imem_addr, 32'h40);
        check("t5_req",  imem_req,  1'b1);
        advance();

        // PC wrap, then reset in the middle of a wait
        do_reset(0);
        drive(0, 1, 32'hFFFF_FFFC, 0, 0);
        advance();
        drive(0, 0, 32'h0, 0, 0);
        check("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        check("t6_pc_wrap",  PC,        32'h0);
        advance();
        drive(0, 0, 32'h0, 0, 0);
        check("t6_addr_wrap", imem_addr, 32'h0);
        mem_lat_cfg = 3;
        advance();
        plain_cycle();
        drive(1, 0, 32'h0, 0, 0);
        advance();
        check_reset_outputs("t6_midrst");
        drive(0, 0, 32'h0, 0, 0);
        check("t6_idle_req", imem_req, 1'b0);
        advance();
        drive(0, 0, 32'h0, 0, 0);
        check("t6_first_req", imem_req, 1'b1);
        advance();

        // Randomised traffic against the reference model
        do_reset(-1);
        for (int i = 0; i < 800; i++) begin
            logic        r, b, f, sf;
            logic [31:0] ba;
            r  = ($urandom % 100) == 0;
            b  = ($urandom % 100) < 8;
            ba = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                        : ($urandom & 32'h0000_0FFC);
            f  = ($urandom % 100) < 15;
            sf = ($urandom % 100) < 10;
            drive(r, b, ba, f, sf);
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
